// File: rtl/data_checker_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// data_checker_if
// AXI-Stream receive bundle between the packet data generator (or the MAC
// loopback path) and data_checker.
//   tdata  : 512-bit beat data            (master -> slave)
//   tvalid : beat valid                   (master -> slave)
//   tlast  : last beat of a packet        (master -> slave)
//   tready : sink ready                   (slave  -> master)
// -----------------------------------------------------------------------------
interface data_checker_if;
    logic [511:0] tdata;
    logic         tvalid;
    logic         tlast;
    logic         tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/data_checker.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// data_checker
// Receive-side counterpart of the 512-bit packet data generator. Every
// accepted beat is checked against the generator pattern:
//   C  = tdata[63:0]     beat counter
//   P  = tdata[127:64]   packet counter
//   PN = tdata[447:384]  ~P
//   CN = tdata[511:448]  ~C
// The checker hunts for a packet start, then checks each beat and keeps
// packet/beat/error statistics plus a capture of the first error.
//
// Ports
//   clk               clock
//   resetn            synchronous active-low reset
//   clear             one-cycle pulse: zero statistics, back to hunting
//   axis_rx           AXI-Stream sink (AXIS_RX_TDATA/TVALID/TLAST/TREADY)
//   locked            1 while checking (locked to the packet stream)
//   packets_rcvd      beats with TLAST accepted while checking
//   beats_rcvd        beats accepted while checking (incl. the start beat)
//   discarded         beats accepted while hunting, saturating
//   error_count       beats with a nonzero error mask, saturating
//   error_seen        sticky first-error flag
//   first_err_mask    error mask of the first erroneous beat
//   first_err_counter C field of the first erroneous beat
// -----------------------------------------------------------------------------
module data_checker #(
    parameter int          BEATS_PER_PACKET = 4,
    parameter logic [15:0] READY_PATTERN    = 16'hFFFF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                clear,
    data_checker_if.slave       axis_rx,
    output logic                locked,
    output logic [63:0]         packets_rcvd,
    output logic [63:0]         beats_rcvd,
    output logic [31:0]         discarded,
    output logic [31:0]         error_count,
    output logic                error_seen,
    output logic [4:0]          first_err_mask,
    output logic [63:0]         first_err_counter
);

    localparam int LB = (BEATS_PER_PACKET > 1) ? $clog2(BEATS_PER_PACKET) : 1;

    typedef enum logic [0:0] {
        ST_HUNT  = 1'b0,
        ST_CHECK = 1'b1
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

    // Beat counter position within a packet: first beat.
    function automatic logic low_bits_zero(input logic [63:0] v);
        return (v[LB-1:0] == {LB{1'b0}});
    endfunction

    // Beat counter position within a packet: last beat.
    function automatic logic low_bits_all_ones(input logic [63:0] v);
        return (&v[LB-1:0]);
    endfunction

    state_t        state_r;
    logic [15:0]   pattern_r;
    logic          tready_r;
    logic [63:0]   exp_c_r;
    logic [63:0]   exp_p_r;
    logic [63:0]   packets_r;
    logic [63:0]   beats_r;
    logic [31:0]   discarded_r;
    logic [31:0]   errors_r;
    logic          seen_r;
    logic [4:0]    first_mask_r;
    logic [63:0]   first_counter_r;

    logic [63:0]   c_s;
    logic [63:0]   p_s;
    logic [63:0]   pn_s;
    logic [63:0]   cn_s;
    logic [63:0]   ref_c_s;
    logic [63:0]   ref_p_s;
    logic [63:0]   base_p_s;
    logic [63:0]   next_c_s;
    logic [63:0]   next_p_s;
    logic [4:0]    mask_s;
    logic          start_s;
    logic          accept_s;
    logic          check_beat_s;
    logic          hunt_drop_s;

    // The filler between P and PN carries no pattern; fold it so it is consumed.
    logic          unused_s;
    assign unused_s = ^axis_rx.tdata[383:128];

    // Ready throttle: rotate the pattern every cycle, present bit 0 registered.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pattern_r <= READY_PATTERN;
            tready_r  <= 1'b0;
        end else begin
            pattern_r <= {pattern_r[0], pattern_r[15:1]};
            tready_r  <= pattern_r[0];
        end
    end

    // Beat decode, error mask and next expectation.
    always_comb begin
        c_s  = axis_rx.tdata[63:0];
        p_s  = axis_rx.tdata[127:64];
        pn_s = axis_rx.tdata[447:384];
        cn_s = axis_rx.tdata[511:448];

        // While hunting, a start beat is checked against itself, which leaves
        // only the TLAST position able to flag an error on that beat.
        if (state_r == ST_CHECK) begin
            ref_c_s = exp_c_r;
            ref_p_s = exp_p_r;
        end else begin
            ref_c_s = c_s;
            ref_p_s = p_s;
        end

        start_s = low_bits_zero(c_s) && (cn_s == ~c_s) && (pn_s == ~p_s);

        mask_s = {(axis_rx.tlast != low_bits_all_ones(ref_c_s)),
                  (pn_s != ~p_s),
                  (p_s  != ref_p_s),
                  (cn_s != ~c_s),
                  (c_s  != ref_c_s)};

        accept_s     = axis_rx.tvalid & tready_r;
        check_beat_s = accept_s & ((state_r == ST_CHECK) | start_s);
        hunt_drop_s  = accept_s & (state_r == ST_HUNT) & ~start_s;

        // Counter or packet mismatch resynchronises to the received beat so a
        // single dropped beat costs exactly one error.
        if (mask_s[0] | mask_s[2]) begin
            next_c_s = c_s + 64'd1;
            base_p_s = p_s;
        end else begin
            next_c_s = ref_c_s + 64'd1;
            base_p_s = ref_p_s;
        end

        // Packet counter advances on the received TLAST, after any resync.
        if (axis_rx.tlast) begin
            next_p_s = base_p_s + 64'd1;
        end else begin
            next_p_s = base_p_s;
        end
    end

    // Hunt/check FSM with statistics and first-error capture.
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            state_r         <= ST_HUNT;
            exp_c_r         <= 64'd0;
            exp_p_r         <= 64'd0;
            packets_r       <= 64'd0;
            beats_r         <= 64'd0;
            discarded_r     <= 32'd0;
            errors_r        <= 32'd0;
            seen_r          <= 1'b0;
            first_mask_r    <= 5'd0;
            first_counter_r <= 64'd0;
        end else if (check_beat_s) begin
            state_r <= ST_CHECK;
            exp_c_r <= next_c_s;
            exp_p_r <= next_p_s;
            beats_r <= beats_r + 64'd1;
            if (axis_rx.tlast) begin
                packets_r <= packets_r + 64'd1;
            end
            if (mask_s != 5'd0) begin
                errors_r <= sat_inc32(errors_r);
                if (!seen_r) begin
                    seen_r          <= 1'b1;
                    first_mask_r    <= mask_s;
                    first_counter_r <= c_s;
                end
            end
        end else if (hunt_drop_s) begin
            discarded_r <= sat_inc32(discarded_r);
        end
    end

    assign axis_rx.tready    = tready_r;
    assign locked            = (state_r == ST_CHECK);
    assign packets_rcvd      = packets_r;
    assign beats_rcvd        = beats_r;
    assign discarded         = discarded_r;
    assign error_count       = errors_r;
    assign error_seen        = seen_r;
    assign first_err_mask    = first_mask_r;
    assign first_err_counter = first_counter_r;

endmodule

// File: tb/tb_data_checker.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_data_checker
// Two checkers share the clock and reset: dut_a with an always-ready sink and
// dut_b with the 16'hA5A5 throttle. A behavioural model of each checker runs
// alongside and every output is compared against it on every falling edge;
// directed literal expectations pin the model at scenario boundaries.
// -----------------------------------------------------------------------------
module tb_data_checker;

    localparam int          BPP   = 4;
    localparam logic [15:0] PAT_A = 16'hFFFF;
    localparam logic [15:0] PAT_B = 16'hA5A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;
    logic clr_a;
    logic clr_b;

    data_checker_if ifa ();
    data_checker_if ifb ();

    logic        locked_a, seen_a, locked_b, seen_b;
    logic [63:0] pk_a, bt_a, fctr_a, pk_b, bt_b, fctr_b;
    logic [31:0] disc_a, errs_a, disc_b, errs_b;
    logic [4:0]  fmask_a, fmask_b;

    data_checker #(.BEATS_PER_PACKET(BPP), .READY_PATTERN(PAT_A)) dut_a (
        .clk(clk), .resetn(resetn), .clear(clr_a), .axis_rx(ifa),
        .locked(locked_a), .packets_rcvd(pk_a), .beats_rcvd(bt_a),
        .discarded(disc_a), .error_count(errs_a), .error_seen(seen_a),
        .first_err_mask(fmask_a), .first_err_counter(fctr_a)
    );

    data_checker #(.BEATS_PER_PACKET(BPP), .READY_PATTERN(PAT_B)) dut_b (
        .clk(clk), .resetn(resetn), .clear(clr_b), .axis_rx(ifb),
        .locked(locked_b), .packets_rcvd(pk_b), .beats_rcvd(bt_b),
        .discarded(disc_b), .error_count(errs_b), .error_seen(seen_b),
        .first_err_mask(fmask_b), .first_err_counter(fctr_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        tready;
        int          cyc;      // position in the ready pattern
        logic        locked;
        logic [63:0] exp_c;
        logic [63:0] exp_p;
        logic [63:0] pk;
        logic [63:0] bt;
        logic [31:0] disc;
        logic [31:0] errs;
        logic        seen;
        logic [4:0]  fmask;
        logic [63:0] fctr;
    } model_t;

    function automatic model_t step(input model_t m, input logic rstn, input logic clr,
                                    input logic vld, input logic last,
                                    input logic [511:0] d, input logic [15:0] pat);
        model_t      n;
        logic [63:0] c, p, pn, cn, ec, ep;
        logic [4:0]  mask;
        logic        tr;
        int          cy;
        n = m;
        if (!rstn) begin
            n = '0;
            return n;
        end
        tr = pat[m.cyc % 16];
        cy = (m.cyc + 1) % 16;
        c  = d[63:0];
        p  = d[127:64];
        pn = d[447:384];
        cn = d[511:448];
        if (clr) begin
            n = '0;
        end else if (vld && m.tready) begin
            if (!m.locked && !(((c % 64'(BPP)) == 64'd0) && cn == ~c && pn == ~p)) begin
                if (m.disc != 32'hFFFF_FFFF) n.disc = m.disc + 32'd1;
            end else begin
                ec = m.locked ? m.exp_c : c;
                ep = m.locked ? m.exp_p : p;
                mask[0] = (c != ec);
                mask[1] = (cn != ~c);
                mask[2] = (p != ep);
                mask[3] = (pn != ~p);
                mask[4] = (last != ((ec % 64'(BPP)) == 64'(BPP - 1)));
                n.locked = 1'b1;
                n.bt     = m.bt + 64'd1;
                if (mask != 5'd0) begin
                    if (m.errs != 32'hFFFF_FFFF) n.errs = m.errs + 32'd1;
                    if (!m.seen) begin
                        n.seen  = 1'b1;
                        n.fmask = mask;
                        n.fctr  = c;
                    end
                end
                if (mask[0] || mask[2]) begin
                    ec = c;
                    ep = p;
                end
                n.exp_c = ec + 64'd1;
                n.exp_p = last ? ep + 64'd1 : ep;
                if (last) n.pk = m.pk + 64'd1;
            end
        end
        n.tready = tr;
        n.cyc    = cy;
        return n;
    endfunction

    model_t ma = '0;
    model_t mb = '0;
    bit     mvalid = 1'b0;

    // Compare both DUTs against their models, then advance the models with the
    // inputs the next rising edge will see.
    always @(negedge clk) begin
        if (mvalid) begin
            cmp("a.tready", ifa.tready, ma.tready);
            cmp("a.locked", locked_a, ma.locked);
            cmp("a.packets", pk_a, ma.pk);
            cmp("a.beats", bt_a, ma.bt);
            cmp("a.discarded", disc_a, ma.disc);
            cmp("a.errors", errs_a, ma.errs);
            cmp("a.seen", seen_a, ma.seen);
            cmp("a.fmask", fmask_a, ma.fmask);
            cmp("a.fctr", fctr_a, ma.fctr);
            cmp("b.tready", ifb.tready, mb.tready);
            cmp("b.locked", locked_b, mb.locked);
            cmp("b.packets", pk_b, mb.pk);
            cmp("b.beats", bt_b, mb.bt);
            cmp("b.discarded", disc_b, mb.disc);
            cmp("b.errors", errs_b, mb.errs);
            cmp("b.seen", seen_b, mb.seen);
            cmp("b.fmask", fmask_b, mb.fmask);
            cmp("b.fctr", fctr_b, mb.fctr);
        end
        ma = step(ma, resetn, clr_a, ifa.tvalid, ifa.tlast, ifa.tdata, PAT_A);
        mb = step(mb, resetn, clr_b, ifb.tvalid, ifb.tlast, ifb.tdata, PAT_B);
        if (!resetn) mvalid = 1'b1;
    end

    // ---------------- stimulus ----------------
    task automatic send(input bit sel, input logic [63:0] c, input logic [63:0] p,
                        input bit last, input logic [63:0] cn_x, input logic [63:0] p_x,
                        input bit do_clr);
        logic [511:0] d;
        bit           rdy;
        int           n;
        d = {~c ^ cn_x, ~p, {8{32'hA5A5_5A5A}}, p ^ p_x, c};
        if (sel) begin
            ifb.tdata = d; ifb.tlast = last; ifb.tvalid = 1'b1;
        end else begin
            ifa.tdata = d; ifa.tlast = last; ifa.tvalid = 1'b1;
        end
        rdy = 1'b0;
        n   = 0;
        while (!rdy && n < 64) begin
            rdy = sel ? ifb.tready : ifa.tready;
            if (rdy && do_clr) begin
                if (sel) clr_b = 1'b1; else clr_a = 1'b1;
            end
            @(posedge clk);
            #1;
            clr_a = 1'b0;
            clr_b = 1'b0;
            n++;
        end
        checks++;
        if (!rdy) begin
            failures++;
            $display("FAIL handshake c=%0h: actual=no tready in 64 cycles required=accept", c);
        end
        if (sel) ifb.tvalid = 1'b0; else ifa.tvalid = 1'b0;
    endtask

    // Generator stream: beat i carries C=c0+i, P=p0+i/BPP, TLAST on the last
    // beat of each packet. Index arguments of -1 disable the corresponding fault.
    task automatic run_stream(input bit sel, input logic [63:0] c0, input logic [63:0] p0,
                              input int i_from, input int i_to, input int drop_i,
                              input int cnbad_i, input int pbad_i, input int nolast_i,
                              input int clr_i);
        for (int i = i_from; i < i_to; i++) begin
            if (i != drop_i) begin
                send(sel, c0 + 64'(i), p0 + 64'(i / BPP),
                     ((i % BPP) == BPP - 1) && (i != nolast_i),
                     (i == cnbad_i) ? 64'h1 : 64'h0,
                     (i == pbad_i) ? 64'h10 : 64'h0,
                     i == clr_i);
            end
        end
    endtask

    task automatic pulse_clear_a();
        clr_a = 1'b1;
        @(posedge clk);
        #1;
        clr_a = 1'b0;
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        clr_a = 1'b0; clr_b = 1'b0;
        ifa.tvalid = 1'b0; ifa.tlast = 1'b0; ifa.tdata = '0;
        ifb.tvalid = 1'b0; ifb.tlast = 1'b0; ifb.tdata = '0;
        repeat (3) @(posedge clk);
        #1;
        cmp("rst.tready_a", ifa.tready, 1'b0);
        cmp("rst.locked_a", locked_a, 1'b0);
        cmp("rst.packets_a", pk_a, 64'd0);
        cmp("rst.errors_a", errs_a, 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        cmp("rst.tready_a_after", ifa.tready, 1'b1);
        cmp("rst.tready_b_after", ifb.tready, 1'b1);  // A5A5 bit 0
        @(posedge clk);
        #1;
        cmp("rst.tready_b_bit1", ifb.tready, 1'b0);   // A5A5 bit 1

        // Clean 3-packet stream
        run_stream(1'b0, 64'd0, 64'd0, 0, 12, -1, -1, -1, -1, -1);
        cmp("gen.packets", pk_a, 64'd3);
        cmp("gen.beats", bt_a, 64'd12);
        cmp("gen.errors", errs_a, 32'd0);
        cmp("gen.locked", locked_a, 1'b1);
        cmp("gen.discarded", disc_a, 32'd0);

        // Start mid-stream at C=2: two beats discarded, lock at C=4
        pulse_clear_a();
        cmp("clr.locked", locked_a, 1'b0);
        run_stream(1'b0, 64'd0, 64'd0, 2, 12, -1, -1, -1, -1, -1);
        cmp("mid.discarded", disc_a, 32'd2);
        cmp("mid.beats", bt_a, 64'd8);
        cmp("mid.packets", pk_a, 64'd2);
        cmp("mid.errors", errs_a, 32'd0);

        // Reset in the middle of a packet drops back to hunting
        pulse_clear_a();
        run_stream(1'b0, 64'd0, 64'd0, 0, 2, -1, -1, -1, -1, -1);
        cmp("midrst.locked_before", locked_a, 1'b1);
        pulse_reset();
        cmp("midrst.locked", locked_a, 1'b0);
        cmp("midrst.beats", bt_a, 64'd0);

        // Dropped beat C=5: one counter error at C=6, then resynchronised
        run_stream(1'b0, 64'd0, 64'd0, 0, 12, 5, -1, -1, -1, -1);
        cmp("drop.errors", errs_a, 32'd1);
        cmp("drop.fmask", fmask_a, 5'b00001);
        cmp("drop.fctr", fctr_a, 64'd6);
        cmp("drop.seen", seen_a, 1'b1);
        cmp("drop.beats", bt_a, 64'd11);
        cmp("drop.packets", pk_a, 64'd3);

        // CN corrupt at C=9, then P corrupt at C=13; capture keeps the first
        pulse_clear_a();
        cmp("clr.seen", seen_a, 1'b0);
        run_stream(1'b0, 64'd0, 64'd0, 0, 10, -1, 9, -1, -1, -1);
        cmp("cn.errors", errs_a, 32'd1);
        cmp("cn.fmask", fmask_a, 5'b00010);
        cmp("cn.fctr", fctr_a, 64'd9);
        run_stream(1'b0, 64'd0, 64'd0, 10, 14, -1, -1, 13, -1, -1);
        cmp("p.errors", errs_a, 32'd2);
        cmp("p.fmask", fmask_a, 5'b00010);
        cmp("p.fctr", fctr_a, 64'd9);
        run_stream(1'b0, 64'd0, 64'd0, 14, 16, -1, -1, -1, -1, -1);
        cmp("p.fctr_final", fctr_a, 64'd9);

        // Missing TLAST on C=3
        pulse_clear_a();
        run_stream(1'b0, 64'd0, 64'd0, 0, 12, -1, -1, -1, 3, -1);
        cmp("nolast.fmask", fmask_a, 5'b10000);
        cmp("nolast.fctr", fctr_a, 64'd3);
        cmp("nolast.packets", pk_a, 64'd2);

        // Beat counter wrapping from all-ones to zero is not an error
        pulse_clear_a();
        run_stream(1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd7, 0, 8, -1, -1, -1, -1, -1);
        cmp("wrap.errors", errs_a, 32'd0);
        cmp("wrap.packets", pk_a, 64'd2);
        cmp("wrap.beats", bt_a, 64'd8);

        // Throttled 100-packet run with clear coincident with the C=161 accept
        run_stream(1'b1, 64'd0, 64'd0, 0, 161, -1, -1, -1, -1, -1);
        cmp("thr.errors_pre", errs_b, 32'd0);
        cmp("thr.packets_pre", pk_b, 64'd40);
        cmp("thr.beats_pre", bt_b, 64'd161);
        run_stream(1'b1, 64'd0, 64'd0, 161, 162, -1, -1, -1, -1, 161);
        cmp("thr.clr_beats", bt_b, 64'd0);
        cmp("thr.clr_packets", pk_b, 64'd0);
        cmp("thr.clr_locked", locked_b, 1'b0);
        cmp("thr.clr_discarded", disc_b, 32'd0);
        run_stream(1'b1, 64'd0, 64'd0, 162, 400, -1, -1, -1, -1, -1);
        cmp("thr.discarded", disc_b, 32'd2);
        cmp("thr.packets", pk_b, 64'd59);
        cmp("thr.beats", bt_b, 64'd236);
        cmp("thr.errors", errs_b, 32'd0);
        cmp("thr.locked", locked_b, 1'b1);

        repeat (4) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
